syn_current_8b: RTL and testbench

Synaptic current stage that sits directly upstream of the 8-bit QIF neuron and drives its I_syn input. It accepts presynaptic spike events through a valid/ready handshake and looks up a programmable signed weight per synapse. Weighted spikes are accumulated over one timestep, then folded into a leaky (exponentially decaying) current on each timestep tick. The result is published as a saturated signed 8-bit current.

---
 rtl/syn_pkg.sv | 35 +++
 rtl/syn_weight_ram.sv | 36 +++
 rtl/syn_current_8b.sv | 142 ++++++++++++++
 tb/tb_syn_current_8b.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/syn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : syn_pkg
// Description : Shared types, current limits and saturation helper for the
//               synaptic current stage.
// Revision    : 1.0 - initial release
// ============================================================================
package syn_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        DECAY   = 2'd1,
        PUBLISH = 2'd2
    } syn_state_e;

    localparam int I_MAX = 127;
    localparam int I_MIN = -128;

    // Clamp a signed value into the range of a WIDTH-bit two's-complement number.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] val,
                                                      input int                 width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (val > hi)
            return hi;
        else if (val < lo)
            return lo;
        else
            return val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/syn_weight_ram.sv
`default_nettype none
// ============================================================================
// Module      : syn_weight_ram
// Description : N_SYN x 8 synaptic weight register file, one write port and
//               one combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
module syn_weight_ram #(
    parameter int N_SYN  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] r_mem [N_SYN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SYN; i++)
                r_mem[i] <= '0;
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read is combinational: a same-cycle write is only visible next cycle.
    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/syn_current_8b.sv
`default_nettype none
// ============================================================================
// Module      : syn_current_8b
// Description : Weighted spike accumulator with leaky synaptic current,
//               published once per timestep tick as a saturated 8-bit value.
// Revision    : 1.0 - initial release
// ============================================================================
module syn_current_8b
    import syn_pkg::*;
#(
    parameter int N_SYN       = 16,
    parameter int ADDR_W      = 4,
    parameter int ACC_W       = 12,
    parameter int DECAY_SHIFT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spike_valid,
    input  logic [ADDR_W-1:0]   spike_addr,
    output logic                spike_ready,
    input  logic                w_we,
    input  logic [ADDR_W-1:0]   w_addr,
    input  logic [7:0]          w_data,
    input  logic                tick,
    output logic signed [7:0]   I_syn,
    output logic                I_syn_valid,
    output logic                acc_sat,
    output logic                tick_overrun
);

    syn_state_e               r_state;
    syn_state_e               w_state_next;
    logic                     w_ready;
    logic [7:0]               w_rdata;
    logic signed [7:0]        w_weight;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W:0]    w_acc_sum;
    logic signed [ACC_W-1:0]  w_acc_sat;
    logic                     w_acc_ovf;
    logic                     w_spike_fire;
    logic signed [ACC_W+1:0]  w_i_ext;
    logic signed [ACC_W+1:0]  w_i_sum;
    logic signed [7:0]        w_i_clamped;
    logic signed [7:0]        r_i_syn;
    logic signed [7:0]        r_i_next;
    logic                     r_i_valid;
    logic                     r_acc_sat;
    logic                     r_tick_overrun;

    syn_weight_ram #(
        .N_SYN  (N_SYN),
        .ADDR_W (ADDR_W)
    ) u_weight_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_we),
        .waddr (w_addr),
        .wdata (w_data),
        .raddr (spike_addr),
        .rdata (w_rdata)
    );

    assign w_weight     = w_rdata;
    assign w_spike_fire = spike_valid & w_ready;

    // One extra bit holds any acc+weight sum exactly; overflow shows as a sign split.
    assign w_acc_sum = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_weight);
    assign w_acc_ovf = w_acc_sum[ACC_W] ^ w_acc_sum[ACC_W-1];
    assign w_acc_sat = ACC_W'(sat_signed(32'(w_acc_sum), ACC_W));

    assign w_i_ext = (ACC_W+2)'(r_i_syn);
    assign w_i_sum = w_i_ext - (w_i_ext >>> DECAY_SHIFT) + (ACC_W+2)'(r_acc);

    always_comb begin
        w_i_clamped = w_i_sum[7:0];
        if (w_i_sum > I_MAX)
            w_i_clamped = 8'(I_MAX);
        else if (w_i_sum < I_MIN)
            w_i_clamped = 8'(I_MIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ACCUM;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        case (r_state)
            ACCUM: begin
                w_ready = 1'b1;
                if (tick)
                    w_state_next = DECAY;
            end
            DECAY:   w_state_next = PUBLISH;
            PUBLISH: w_state_next = ACCUM;
            default: w_state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc          <= '0;
            r_i_syn        <= '0;
            r_i_next       <= '0;
            r_i_valid      <= 1'b0;
            r_acc_sat      <= 1'b0;
            r_tick_overrun <= 1'b0;
        end else begin
            r_i_valid <= 1'b0;
            if (tick && (r_state != ACCUM))
                r_tick_overrun <= 1'b1;
            case (r_state)
                ACCUM: begin
                    if (w_spike_fire) begin
                        r_acc <= w_acc_sat;
                        if (w_acc_ovf)
                            r_acc_sat <= 1'b1;
                    end
                end
                DECAY:   r_i_next <= w_i_clamped;
                PUBLISH: begin
                    r_i_syn   <= r_i_next;
                    r_i_valid <= 1'b1;
                    r_acc     <= '0;
                end
                default: ;
            endcase
        end
    end

    assign spike_ready  = w_ready;
    assign I_syn        = r_i_syn;
    assign I_syn_valid  = r_i_valid;
    assign acc_sat      = r_acc_sat;
    assign tick_overrun = r_tick_overrun;

endmodule
`default_nettype wire

// File: tb/tb_syn_current_8b.sv
`default_nettype none
// ============================================================================
// Module      : tb_syn_current_8b
// Description : Self-checking bench for syn_current_8b against a behavioural
//               model of the weighted, leaky synaptic current.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_syn_current_8b;

    localparam int N_SYN   = 16;
    localparam int ADDR_W  = 4;
    localparam int ACC_W   = 12;
    localparam int DSHIFT  = 2;
    localparam int ACC_MAX = 2047;
    localparam int ACC_MIN = -2048;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              spike_valid = 1'b0;
    logic [ADDR_W-1:0] spike_addr = '0;
    logic              spike_ready;
    logic              w_we = 1'b0;
    logic [ADDR_W-1:0] w_addr = '0;
    logic [7:0]        w_data = '0;
    logic              tick = 1'b0;
    logic signed [7:0] I_syn;
    logic              I_syn_valid;
    logic              acc_sat;
    logic              tick_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_w [N_SYN];
    int m_acc;
    int m_i;
    bit m_acc_sat;
    bit m_ovr;

    syn_current_8b #(
        .N_SYN       (N_SYN),
        .ADDR_W      (ADDR_W),
        .ACC_W       (ACC_W),
        .DECAY_SHIFT (DSHIFT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spike_valid  (spike_valid),
        .spike_addr   (spike_addr),
        .spike_ready  (spike_ready),
        .w_we         (w_we),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .tick         (tick),
        .I_syn        (I_syn),
        .I_syn_valid  (I_syn_valid),
        .acc_sat      (acc_sat),
        .tick_overrun (tick_overrun)
    );

    always #5 clk = ~clk;

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // floor(v / 2^DSHIFT) using plain integer arithmetic
    function automatic int floor_div(input int v);
        int d;
        d = 1 << DSHIFT;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_SYN; i++) m_w[i] = 0;
        m_acc = 0; m_i = 0; m_acc_sat = 0; m_ovr = 0;
    endtask

    task automatic model_spike(input int a);
        int s;
        s = m_acc + m_w[a];
        if (s > ACC_MAX || s < ACC_MIN) m_acc_sat = 1;
        m_acc = clamp(s, ACC_MIN, ACC_MAX);
    endtask

    task automatic model_tick();
        m_i   = clamp(m_i - floor_div(m_i) + m_acc, -128, 127);
        m_acc = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input int a, input int v);
        w_we = 1'b1; w_addr = ADDR_W'(a); w_data = 8'(v);
        step();
        w_we = 1'b0;
        m_w[a] = v;
    endtask

    task automatic send_spike(input int a);
        spike_valid = 1'b1; spike_addr = ADDR_W'(a);
        n_checks++;
        if (spike_ready !== 1'b1) begin
            n_fail++; $display("FAIL spike_ready_accum: got %b want 1", spike_ready);
        end
        step();
        spike_valid = 1'b0;
        model_spike(a);
    endtask

    // Called just after the edge that sampled tick in ACCUM.
    task automatic finish_tick(input string name);
        int prev;
        prev = m_i;
        tick = 1'b0;
        n_checks++;
        if (spike_ready !== 1'b0 || I_syn_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s_decay: ready=%b valid=%b want 0 0", name, spike_ready, I_syn_valid);
        end
        step();
        n_checks++;
        if (spike_ready !== 1'b0 || I_syn_valid !== 1'b0 || int'(I_syn) != prev) begin
            n_fail++; $display("FAIL %s_publish: ready=%b valid=%b I=%0d want 0 0 %0d", name, spike_ready, I_syn_valid, I_syn, prev);
        end
        step();
        model_tick();
        n_checks++;
        if (I_syn_valid !== 1'b1 || int'(I_syn) != m_i || spike_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s_result: valid=%b I=%0d ready=%b want 1 %0d 1", name, I_syn_valid, I_syn, spike_ready, m_i);
        end
        step();
        n_checks++;
        if (I_syn_valid !== 1'b0 || int'(I_syn) != m_i || acc_sat !== m_acc_sat || tick_overrun !== m_ovr) begin
            n_fail++; $display("FAIL %s_hold: valid=%b I=%0d sat=%b ovr=%b want 0 %0d %b %b", name, I_syn_valid, I_syn, acc_sat, tick_overrun, m_i, m_acc_sat, m_ovr);
        end
    endtask

    task automatic do_tick(input string name);
        tick = 1'b1;
        step();
        finish_tick(name);
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_checks++;
        if (I_syn !== 8'sd0 || I_syn_valid !== 1'b0 || acc_sat !== 1'b0 || tick_overrun !== 1'b0 || spike_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset: I=%0d valid=%b sat=%b ovr=%b ready=%b want 0 0 0 0 1", I_syn, I_syn_valid, acc_sat, tick_overrun, spike_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        write_w(3, 20);
        write_w(5, -7);
        send_spike(3); send_spike(3); send_spike(3); send_spike(5);
        do_tick("basic");
        n_checks++;
        if (int'(I_syn) != 53) begin n_fail++; $display("FAIL basic_53: got %0d want 53", I_syn); end
        do_tick("decay1");
        n_checks++;
        if (int'(I_syn) != 40) begin n_fail++; $display("FAIL decay_40: got %0d want 40", I_syn); end
        do_tick("decay2");
        n_checks++;
        if (int'(I_syn) != 30) begin n_fail++; $display("FAIL decay_30: got %0d want 30", I_syn); end
    endtask

    task automatic test_i_sat();
        write_w(0, 100);
        repeat (10) send_spike(0);
        do_tick("isat_hi");
        n_checks++;
        if (int'(I_syn) != 127) begin n_fail++; $display("FAIL isat_127: got %0d want 127", I_syn); end
        write_w(1, -128);
        send_spike(1); send_spike(1);
        do_tick("isat_lo");
        n_checks++;
        if (int'(I_syn) != -128) begin n_fail++; $display("FAIL isat_m128: got %0d want -128", I_syn); end
    endtask

    task automatic test_spike_tick();
        spike_valid = 1'b1; spike_addr = ADDR_W'(3); tick = 1'b1;
        step();
        spike_valid = 1'b0;
        model_spike(3);
        finish_tick("spike_tick");
    endtask

    task automatic test_overrun();
        send_spike(5);
        n_checks++;
        if (tick_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pre: got %b want 0", tick_overrun); end
        tick = 1'b1;
        step();
        // Second tick and a spike both land while the stage is busy.
        spike_valid = 1'b1; spike_addr = ADDR_W'(3);
        n_checks++;
        if (spike_ready !== 1'b0 || tick_overrun !== 1'b0) begin
            n_fail++; $display("FAIL ovr_decay: ready=%b ovr=%b want 0 0", spike_ready, tick_overrun);
        end
        step();
        tick = 1'b0;
        m_ovr = 1;
        n_checks++;
        if (spike_ready !== 1'b0 || tick_overrun !== 1'b1) begin
            n_fail++; $display("FAIL ovr_set: ready=%b ovr=%b want 0 1", spike_ready, tick_overrun);
        end
        step();
        spike_valid = 1'b0;
        model_tick();
        n_checks++;
        if (I_syn_valid !== 1'b1 || int'(I_syn) != m_i) begin
            n_fail++; $display("FAIL ovr_result: valid=%b I=%0d want 1 %0d", I_syn_valid, I_syn, m_i);
        end
        step();
        n_checks++;
        if (I_syn_valid !== 1'b0 || tick_overrun !== 1'b1) begin
            n_fail++; $display("FAIL ovr_sticky: valid=%b ovr=%b want 0 1", I_syn_valid, tick_overrun);
        end
        do_tick("ovr_after");
    endtask

    task automatic test_weight_collision();
        write_w(6, 10);
        w_we = 1'b1; w_addr = ADDR_W'(6); w_data = 8'(-50);
        spike_valid = 1'b1; spike_addr = ADDR_W'(6);
        step();
        w_we = 1'b0; spike_valid = 1'b0;
        model_spike(6);
        m_w[6] = -50;
        send_spike(6);
        do_tick("collision");
    endtask

    task automatic test_acc_sat();
        n_checks++;
        if (acc_sat !== 1'b0) begin n_fail++; $display("FAIL accsat_pre: got %b want 0", acc_sat); end
        write_w(2, 100);
        repeat (30) send_spike(2);
        n_checks++;
        if (acc_sat !== 1'b1 || m_acc != 2047) begin
            n_fail++; $display("FAIL accsat_set: got %b want 1 (model acc %0d)", acc_sat, m_acc);
        end
        do_tick("accsat");
        n_checks++;
        if (int'(I_syn) != 127) begin n_fail++; $display("FAIL accsat_127: got %0d want 127", I_syn); end
    endtask

    task automatic test_random();
        for (int win = 0; win < 12; win++) begin
            int nw;
            int ns;
            nw = $urandom_range(0, 3);
            for (int k = 0; k < nw; k++) begin
                int d;
                d = $urandom_range(0, 255);
                write_w($urandom_range(0, N_SYN - 1), (d > 127) ? d - 256 : d);
            end
            ns = $urandom_range(0, 8);
            for (int k = 0; k < ns; k++) begin
                send_spike($urandom_range(0, N_SYN - 1));
                if ($urandom_range(0, 1) == 1) step();
            end
            do_tick("random");
        end
    endtask

    task automatic test_midreset();
        write_w(4, 25);
        repeat (4) send_spike(4);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (I_syn !== 8'sd0 || I_syn_valid !== 1'b0 || acc_sat !== 1'b0 || tick_overrun !== 1'b0) begin
            n_fail++; $display("FAIL midreset: I=%0d valid=%b sat=%b ovr=%b want 0 0 0 0", I_syn, I_syn_valid, acc_sat, tick_overrun);
        end
        step();
        rst_n = 1'b1;
        step();
        send_spike(4);
        do_tick("post_reset");
        n_checks++;
        if (int'(I_syn) != 0) begin n_fail++; $display("FAIL post_reset_zero: got %0d want 0", I_syn); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_i_sat();
        test_spike_tick();
        test_overrun();
        test_weight_collision();
        test_acc_sat();
        test_random();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
